// File: rtl/stride_decoder.sv
// Convolution tap sequencer: walks kx/ky/c (plus an optional bias tap) for each output
// channel, handshakes one tap per rd beat, and issues one writeback beat per channel.
//   state | meaning
//   IDLE  | ready for an instruction
//   ISSUE | presenting taps on the rd port
//   WB    | presenting the channel result address on the wb port
//   DONE  | one-cycle op_done pulse
module stride_decoder #(
    parameter int FRAM_AW = 12,
    parameter int KRAM_AW = 12,
    parameter int DATA_W  = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               inst_valid,
    output logic               decoder_ready,
    input  logic [FRAM_AW-1:0] stride_feature_baseaddr,
    input  logic [KRAM_AW-1:0] stride_kernel_baseaddr,
    input  logic [DATA_W-1:0]  stride_feature_chin,
    input  logic [DATA_W-1:0]  stride_feature_chout,
    input  logic [DATA_W-1:0]  stride_feature_width,
    input  logic [DATA_W-1:0]  stride_feature_height,
    input  logic [DATA_W-1:0]  stride_kernel_sizeh,
    input  logic [DATA_W-1:0]  stride_kernel_sizew,
    input  logic               stride_has_bias,
    input  logic               stride_has_relu,
    input  logic [FRAM_AW-1:0] stride_wb_baseaddr,
    output logic               rd_valid,
    input  logic               rd_ready,
    output logic [FRAM_AW-1:0] fram_addr,
    output logic [KRAM_AW-1:0] kram_addr,
    output logic               rd_first,
    output logic               rd_last,
    output logic               rd_bias,
    output logic               wb_valid,
    input  logic               wb_ready,
    output logic [FRAM_AW-1:0] wb_addr,
    output logic               wb_relu,
    output logic               op_done
);

    typedef enum logic [1:0] {IDLE, ISSUE, WB, DONE} state_t;

    state_t             state_q, state_d;
    logic [FRAM_AW-1:0] fbase_q, fbase_d, fw_q, fw_d, plane_q, plane_d;
    logic [DATA_W-1:0]  chin_q, chin_d, chout_q, chout_d, sizeh_q, sizeh_d, sizew_q, sizew_d;
    logic               bias_q, bias_d, relu_q, relu_d, bphase_q, bphase_d;
    logic [DATA_W-1:0]  oc_q, oc_d, c_q, c_d, ky_q, ky_d, kx_q, kx_d;
    logic [FRAM_AW-1:0] chan_q, chan_d, row_q, row_d, fram_q, fram_d, wbaddr_q, wbaddr_d;
    logic [KRAM_AW-1:0] kptr_q, kptr_d;
    logic               last_kx, last_ky, last_c, last_oc, zero_dim;

    assign last_kx  = (kx_q == sizew_q - DATA_W'(1));
    assign last_ky  = (ky_q == sizeh_q - DATA_W'(1));
    assign last_c   = (c_q  == chin_q  - DATA_W'(1));
    assign last_oc  = (oc_q == chout_q - DATA_W'(1));
    assign zero_dim = (stride_feature_chin == '0) || (stride_feature_chout == '0) ||
                      (stride_kernel_sizeh == '0) || (stride_kernel_sizew == '0);

    // Feature addresses are tracked incrementally: chan = base + c*plane, row = chan + ky*width.
    always_comb begin
        state_d  = state_q;
        fbase_d  = fbase_q;
        fw_d     = fw_q;
        plane_d  = plane_q;
        chin_d   = chin_q;
        chout_d  = chout_q;
        sizeh_d  = sizeh_q;
        sizew_d  = sizew_q;
        bias_d   = bias_q;
        relu_d   = relu_q;
        bphase_d = bphase_q;
        oc_d     = oc_q;
        c_d      = c_q;
        ky_d     = ky_q;
        kx_d     = kx_q;
        chan_d   = chan_q;
        row_d    = row_q;
        fram_d   = fram_q;
        wbaddr_d = wbaddr_q;
        kptr_d   = kptr_q;
        case (state_q)
            IDLE: begin
                if (inst_valid) begin
                    fbase_d  = stride_feature_baseaddr;
                    fw_d     = FRAM_AW'(stride_feature_width);
                    plane_d  = FRAM_AW'(stride_feature_width * stride_feature_height);
                    chin_d   = stride_feature_chin;
                    chout_d  = stride_feature_chout;
                    sizeh_d  = stride_kernel_sizeh;
                    sizew_d  = stride_kernel_sizew;
                    bias_d   = stride_has_bias;
                    relu_d   = stride_has_relu;
                    bphase_d = 1'b0;
                    oc_d     = '0;
                    c_d      = '0;
                    ky_d     = '0;
                    kx_d     = '0;
                    chan_d   = stride_feature_baseaddr;
                    row_d    = stride_feature_baseaddr;
                    fram_d   = stride_feature_baseaddr;
                    wbaddr_d = stride_wb_baseaddr;
                    kptr_d   = stride_kernel_baseaddr;
                    state_d  = zero_dim ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (rd_ready) begin
                    kptr_d = kptr_q + KRAM_AW'(1);
                    if (bphase_q) begin
                        bphase_d = 1'b0;
                        state_d  = WB;
                    end else if (!last_kx) begin
                        kx_d   = kx_q + DATA_W'(1);
                        fram_d = fram_q + FRAM_AW'(1);
                    end else if (!last_ky) begin
                        kx_d   = '0;
                        ky_d   = ky_q + DATA_W'(1);
                        row_d  = row_q + fw_q;
                        fram_d = row_q + fw_q;
                    end else if (!last_c) begin
                        kx_d   = '0;
                        ky_d   = '0;
                        c_d    = c_q + DATA_W'(1);
                        chan_d = chan_q + plane_q;
                        row_d  = chan_q + plane_q;
                        fram_d = chan_q + plane_q;
                    end else begin
                        kx_d   = '0;
                        ky_d   = '0;
                        c_d    = '0;
                        chan_d = fbase_q;
                        row_d  = fbase_q;
                        fram_d = fbase_q;
                        if (bias_q) bphase_d = 1'b1;
                        else        state_d  = WB;
                    end
                end
            end
            WB: begin
                if (wb_ready) begin
                    if (last_oc) begin
                        state_d = DONE;
                    end else begin
                        oc_d     = oc_q + DATA_W'(1);
                        wbaddr_d = wbaddr_q + plane_q;
                        state_d  = ISSUE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            fbase_q  <= '0;
            fw_q     <= '0;
            plane_q  <= '0;
            chin_q   <= '0;
            chout_q  <= '0;
            sizeh_q  <= '0;
            sizew_q  <= '0;
            bias_q   <= 1'b0;
            relu_q   <= 1'b0;
            bphase_q <= 1'b0;
            oc_q     <= '0;
            c_q      <= '0;
            ky_q     <= '0;
            kx_q     <= '0;
            chan_q   <= '0;
            row_q    <= '0;
            fram_q   <= '0;
            wbaddr_q <= '0;
            kptr_q   <= '0;
        end else begin
            state_q  <= state_d;
            fbase_q  <= fbase_d;
            fw_q     <= fw_d;
            plane_q  <= plane_d;
            chin_q   <= chin_d;
            chout_q  <= chout_d;
            sizeh_q  <= sizeh_d;
            sizew_q  <= sizew_d;
            bias_q   <= bias_d;
            relu_q   <= relu_d;
            bphase_q <= bphase_d;
            oc_q     <= oc_d;
            c_q      <= c_d;
            ky_q     <= ky_d;
            kx_q     <= kx_d;
            chan_q   <= chan_d;
            row_q    <= row_d;
            fram_q   <= fram_d;
            wbaddr_q <= wbaddr_d;
            kptr_q   <= kptr_d;
        end
    end

    assign decoder_ready = (state_q == IDLE);
    assign rd_valid      = (state_q == ISSUE);
    assign wb_valid      = (state_q == WB);
    assign op_done       = (state_q == DONE);
    assign fram_addr     = fram_q;
    assign kram_addr     = kptr_q;
    assign rd_first      = rd_valid && !bphase_q && (c_q == '0) && (ky_q == '0) && (kx_q == '0);
    assign rd_last       = rd_valid && (bias_q ? bphase_q : (last_kx && last_ky && last_c));
    assign rd_bias       = rd_valid && bphase_q;
    assign wb_addr       = wbaddr_q;
    assign wb_relu       = wb_valid && relu_q;

endmodule

// File: tb/tb_stride_decoder.sv
// Randomized self-checking bench for stride_decoder; expected taps and writebacks come from
// nested-loop address formulas evaluated per instruction.
module tb_stride_decoder;

    localparam int FAW = 12;
    localparam int KAW = 12;
    localparam int DW  = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           inst_valid = 1'b0;
    logic           decoder_ready;
    logic [FAW-1:0] stride_feature_baseaddr = '0;
    logic [KAW-1:0] stride_kernel_baseaddr = '0;
    logic [DW-1:0]  stride_feature_chin = '0, stride_feature_chout = '0;
    logic [DW-1:0]  stride_feature_width = '0, stride_feature_height = '0;
    logic [DW-1:0]  stride_kernel_sizeh = '0, stride_kernel_sizew = '0;
    logic           stride_has_bias = 1'b0, stride_has_relu = 1'b0;
    logic [FAW-1:0] stride_wb_baseaddr = '0;
    logic           rd_valid, rd_ready = 1'b0;
    logic [FAW-1:0] fram_addr;
    logic [KAW-1:0] kram_addr;
    logic           rd_first, rd_last, rd_bias;
    logic           wb_valid, wb_ready = 1'b0;
    logic [FAW-1:0] wb_addr;
    logic           wb_relu, op_done;

    always #5 clk = ~clk;

    stride_decoder #(.FRAM_AW(FAW), .KRAM_AW(KAW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .decoder_ready(decoder_ready),
        .stride_feature_baseaddr(stride_feature_baseaddr),
        .stride_kernel_baseaddr(stride_kernel_baseaddr),
        .stride_feature_chin(stride_feature_chin), .stride_feature_chout(stride_feature_chout),
        .stride_feature_width(stride_feature_width), .stride_feature_height(stride_feature_height),
        .stride_kernel_sizeh(stride_kernel_sizeh), .stride_kernel_sizew(stride_kernel_sizew),
        .stride_has_bias(stride_has_bias), .stride_has_relu(stride_has_relu),
        .stride_wb_baseaddr(stride_wb_baseaddr),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .fram_addr(fram_addr), .kram_addr(kram_addr),
        .rd_first(rd_first), .rd_last(rd_last), .rd_bias(rd_bias),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_relu(wb_relu),
        .op_done(op_done)
    );

    int checks = 0;
    int errors = 0;

    int unsigned t_fbase, t_kbase, t_wbbase, t_chin, t_chout, t_w, t_h, t_kh, t_kw;
    bit          t_bias, t_relu;

    int unsigned e_fram[$], e_kram[$], e_wb[$];
    bit          e_first[$], e_last[$], e_bias[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void build_model();
        longint unsigned plane, k, a;
        bit first;
        e_fram.delete(); e_kram.delete(); e_wb.delete();
        e_first.delete(); e_last.delete(); e_bias.delete();
        if (t_chin == 0 || t_chout == 0 || t_kh == 0 || t_kw == 0) return;
        plane = (longint'(t_w) * longint'(t_h)) % 4096;
        k = t_kbase;
        for (int unsigned oc = 0; oc < t_chout; oc++) begin
            first = 1'b1;
            for (int unsigned c = 0; c < t_chin; c++)
                for (int unsigned ky = 0; ky < t_kh; ky++)
                    for (int unsigned kx = 0; kx < t_kw; kx++) begin
                        a = (t_fbase + c * plane + ky * longint'(t_w) + kx) % 4096;
                        e_fram.push_back(int'(a));
                        e_kram.push_back(int'(k % 4096));
                        e_first.push_back(first);
                        e_last.push_back(!t_bias && c == t_chin - 1 && ky == t_kh - 1 && kx == t_kw - 1);
                        e_bias.push_back(1'b0);
                        first = 1'b0;
                        k++;
                    end
            if (t_bias) begin
                e_fram.push_back(0);
                e_kram.push_back(int'(k % 4096));
                e_first.push_back(1'b0);
                e_last.push_back(1'b1);
                e_bias.push_back(1'b1);
                k++;
            end
            e_wb.push_back(int'((t_wbbase + oc * plane) % 4096));
        end
    endfunction

    task automatic drive_fields();
        stride_feature_baseaddr = FAW'(t_fbase);
        stride_kernel_baseaddr  = KAW'(t_kbase);
        stride_wb_baseaddr      = FAW'(t_wbbase);
        stride_feature_chin     = t_chin;
        stride_feature_chout    = t_chout;
        stride_feature_width    = t_w;
        stride_feature_height   = t_h;
        stride_kernel_sizeh     = t_kh;
        stride_kernel_sizew     = t_kw;
        stride_has_bias         = t_bias;
        stride_has_relu         = t_relu;
    endtask

    task automatic scramble_fields();
        stride_feature_baseaddr = FAW'($urandom);
        stride_kernel_baseaddr  = KAW'($urandom);
        stride_wb_baseaddr      = FAW'($urandom);
        stride_feature_chin     = $urandom_range(0, 3);
        stride_feature_chout    = $urandom_range(0, 3);
        stride_feature_width    = $urandom;
        stride_feature_height   = $urandom;
        stride_kernel_sizeh     = $urandom_range(0, 3);
        stride_kernel_sizew     = $urandom_range(0, 3);
        stride_has_bias         = 1'($urandom);
        stride_has_relu         = 1'($urandom);
    endtask

    task automatic run_inst(input bit stall, input bit hold_valid, input string name);
        int ri, wi, cyc;
        bit done, zero, st_rd, st_wb;
        logic [63:0] st_rdv, st_wbv, rdv, wbv;
        ri = 0; wi = 0; cyc = 0; done = 0; st_rd = 0; st_wb = 0;
        st_rdv = '0; st_wbv = '0;
        build_model();
        zero = (e_fram.size() == 0);
        @(posedge clk); #1;
        drive_fields();
        inst_valid = 1'b1;
        rd_ready = stall ? 1'($urandom) : 1'b1;
        wb_ready = stall ? 1'($urandom) : 1'b1;
        @(negedge clk);
        chk({name, "_accept_ready"}, decoder_ready, 1);
        @(posedge clk); #1;
        if (hold_valid) scramble_fields();
        else inst_valid = 1'b0;
        while (!done && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) chk({name, "_first_state"}, {rd_valid, op_done}, zero ? 2'b01 : 2'b10);
            chk({name, "_rd_wb_excl"}, rd_valid & wb_valid, 0);
            rdv = {rd_bias ? 12'h0 : fram_addr, kram_addr, rd_first, rd_last, rd_bias};
            wbv = {wb_addr, wb_relu};
            if (st_rd) chk({name, "_rd_stall_hold"}, {rd_valid, rdv}, {1'b1, st_rdv});
            if (st_wb) chk({name, "_wb_stall_hold"}, {wb_valid, wbv}, {1'b1, st_wbv});
            st_rd = 0; st_wb = 0;
            if (rd_valid) begin
                if (rd_ready) begin
                    if (ri < e_fram.size()) begin
                        chk({name, "_kram"}, kram_addr, e_kram[ri]);
                        chk({name, "_flags"}, {rd_first, rd_last, rd_bias},
                            {e_first[ri], e_last[ri], e_bias[ri]});
                        if (!e_bias[ri]) chk({name, "_fram"}, fram_addr, e_fram[ri]);
                    end else chk({name, "_rd_extra_beat"}, ri, e_fram.size());
                    ri++;
                end else begin
                    st_rd = 1; st_rdv = rdv;
                end
            end
            if (wb_valid) begin
                if (wb_ready) begin
                    if (wi < e_wb.size()) chk({name, "_wb"}, wbv, {e_wb[wi][11:0], t_relu});
                    else chk({name, "_wb_extra_beat"}, wi, e_wb.size());
                    wi++;
                end else begin
                    st_wb = 1; st_wbv = wbv;
                end
            end
            if (op_done) done = 1;
            @(posedge clk); #1;
            rd_ready = stall ? 1'($urandom) : 1'b1;
            wb_ready = stall ? 1'($urandom) : 1'b1;
            if (done) inst_valid = 1'b0;
        end
        chk({name, "_op_done_seen"}, done, 1);
        chk({name, "_rd_beats"}, ri, e_fram.size());
        chk({name, "_wb_beats"}, wi, e_wb.size());
        @(negedge clk);
        chk({name, "_after_done"}, {op_done, decoder_ready, rd_valid, wb_valid}, 4'b0100);
    endtask

    task automatic set_basic();
        t_fbase = 10; t_kbase = 0; t_wbbase = 100; t_w = 4; t_h = 4;
        t_chin = 1; t_chout = 1; t_kh = 2; t_kw = 2; t_bias = 0; t_relu = 0;
    endtask

    task automatic set_bias();
        t_fbase = 0; t_kbase = 0; t_wbbase = 200; t_w = 3; t_h = 3;
        t_chin = 2; t_chout = 2; t_kh = 1; t_kw = 1; t_bias = 1; t_relu = 1;
    endtask

    initial begin
        bit found;
        #12;
        chk("reset_values",
            {decoder_ready, rd_valid, wb_valid, op_done, rd_first, rd_last, rd_bias, wb_relu,
             fram_addr, kram_addr, wb_addr},
            {8'b1000_0000, 36'h0});
        @(posedge clk); #2 rst_n = 1'b1;

        set_basic();
        run_inst(0, 0, "basic");

        set_bias();
        run_inst(0, 1, "bias_hold");

        t_fbase = 4094; t_kbase = 4095; t_wbbase = 4000; t_w = 4; t_h = 2;
        t_chin = 1; t_chout = 1; t_kh = 1; t_kw = 3; t_bias = 0; t_relu = 0;
        run_inst(0, 0, "wrap");

        set_basic(); t_chin = 0;
        run_inst(0, 0, "zero_chin");
        set_basic(); t_kw = 0;
        run_inst(1, 0, "zero_kw");

        set_basic();
        @(posedge clk); #1;
        drive_fields();
        inst_valid = 1'b1; rd_ready = 1'b1; wb_ready = 1'b1;
        @(posedge clk); #1 inst_valid = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (rd_valid && kram_addr == 2) found = 1;
        end
        chk("rst_tap3_reached", found, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_outputs",
            {decoder_ready, rd_valid, wb_valid, op_done, rd_first, rd_last, rd_bias, wb_relu,
             fram_addr, kram_addr, wb_addr},
            {8'b1000_0000, 36'h0});
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_idle", {rd_valid, wb_valid, decoder_ready}, 3'b001);
        end
        run_inst(0, 0, "replay");

        set_bias();
        run_inst(1, 0, "bias_stall");
        set_basic();
        run_inst(1, 1, "basic_stall");

        for (int n = 0; n < 8; n++) begin
            t_fbase = $urandom_range(0, 4095); t_kbase = $urandom_range(0, 4095);
            t_wbbase = $urandom_range(0, 4095);
            t_chin = $urandom_range(1, 3); t_chout = $urandom_range(1, 3);
            t_kh = $urandom_range(1, 3); t_kw = $urandom_range(1, 3);
            t_w = (n == 7) ? $urandom : $urandom_range(1, 8);
            t_h = (n == 6) ? $urandom : $urandom_range(1, 8);
            t_bias = 1'($urandom); t_relu = 1'($urandom);
            if (n == 5) t_chout = 0;
            run_inst(1, n[0], "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
